// File: rtl/credit_switch_allocator.sv
// Five-port credit-based switch allocator: per-output round-robin arbitration
// with packet locking (wormhole) and downstream credit tracking.
module credit_switch_allocator #(
  parameter int unsigned CREDITS = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] req_N,
  input  logic [4:0] req_E,
  input  logic [4:0] req_W,
  input  logic [4:0] req_S,
  input  logic [4:0] req_L,
  input  logic [4:0] tail,
  input  logic [4:0] credit_in,
  output logic [4:0] grant,
  output logic [4:0] xbar_sel_N,
  output logic [4:0] xbar_sel_E,
  output logic [4:0] xbar_sel_W,
  output logic [4:0] xbar_sel_S,
  output logic [4:0] xbar_sel_L,
  output logic [4:0] out_valid,
  output logic       credit_err
);

  localparam int unsigned PORTS  = 5;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CRED_W = 3;
  localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(PORTS - 1);

  typedef enum logic {IDLE, LOCKED} state_t;

  logic [PORTS-1:0]  req      [PORTS];
  logic [PORTS-1:0]  req_ok;
  logic [PORTS-1:0]  want     [PORTS];  // want[o][i]: input i validly requests output o

  state_t            state    [PORTS];
  logic [IDX_W-1:0]  owner    [PORTS];
  logic [IDX_W-1:0]  rr       [PORTS];
  logic [CRED_W-1:0] credit   [PORTS];
  logic [PORTS-1:0]  xsel     [PORTS];

  logic [IDX_W-1:0]  win      [PORTS];
  logic [PORTS-1:0]  win_ok;
  logic [PORTS-1:0]  grant_d;
  logic [PORTS-1:0]  xsel_d   [PORTS];

  assign req[0] = req_N;
  assign req[1] = req_E;
  assign req[2] = req_W;
  assign req[3] = req_S;
  assign req[4] = req_L;

  assign xbar_sel_N = xsel[0];
  assign xbar_sel_E = xsel[1];
  assign xbar_sel_W = xsel[2];
  assign xbar_sel_S = xsel[3];
  assign xbar_sel_L = xsel[4];

  function automatic logic [IDX_W-1:0] rr_idx(input logic [IDX_W-1:0] base, input int k);
    return IDX_W'((int'(base) + k) % int'(PORTS));
  endfunction

  // Multi-hot request vectors are dropped for the cycle
  always_comb begin
    for (int i = 0; i < PORTS; i++) begin
      req_ok[i] = $onehot(req[i]);
    end
    for (int o = 0; o < PORTS; o++) begin
      for (int i = 0; i < PORTS; i++) begin
        want[o][i] = req_ok[i] & req[i][o];
      end
    end
  end

  // Per-output arbitration; descending scan so the nearest requester after rr wins
  always_comb begin
    grant_d = '0;
    for (int o = 0; o < PORTS; o++) begin
      win[o]    = rr[o];
      win_ok[o] = 1'b0;
      xsel_d[o] = '0;
      if (state[o] == LOCKED) begin
        win[o]    = owner[o];
        win_ok[o] = want[o][owner[o]];
      end else begin
        for (int k = PORTS - 1; k >= 0; k--) begin
          if (want[o][rr_idx(rr[o], k)]) begin
            win[o]    = rr_idx(rr[o], k);
            win_ok[o] = 1'b1;
          end
        end
      end
      if (credit[o] == '0) begin
        win_ok[o] = 1'b0;
      end
      if (win_ok[o]) begin
        xsel_d[o][win[o]] = 1'b1;
        grant_d[win[o]]   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      grant      <= '0;
      out_valid  <= '0;
      credit_err <= 1'b0;
      for (int o = 0; o < PORTS; o++) begin
        state[o]  <= IDLE;
        owner[o]  <= '0;
        rr[o]     <= '0;
        credit[o] <= CRED_MAX;
        xsel[o]   <= '0;
      end
    end else begin
      grant     <= grant_d;
      out_valid <= win_ok;
      for (int o = 0; o < PORTS; o++) begin
        xsel[o] <= xsel_d[o];
        if (win_ok[o]) begin
          if (tail[win[o]]) begin
            state[o] <= IDLE;
            rr[o]    <= (win[o] == LAST_IDX) ? '0 : win[o] + IDX_W'(1);
          end else begin
            state[o] <= LOCKED;
            owner[o] <= win[o];
          end
        end
        // A returned credit beyond capacity is discarded and flagged
        if (credit_in[o] && !win_ok[o]) begin
          if (credit[o] == CRED_MAX) begin
            credit_err <= 1'b1;
          end else begin
            credit[o] <= credit[o] + CRED_W'(1);
          end
        end else if (!credit_in[o] && win_ok[o]) begin
          credit[o] <= credit[o] - CRED_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_credit_switch_allocator.sv
// Directed self-checking bench for credit_switch_allocator (CREDITS = 4).
module tb_credit_switch_allocator;

  logic       clk;
  logic       rst;
  logic [4:0] req_N, req_E, req_W, req_S, req_L;
  logic [4:0] tail;
  logic [4:0] credit_in;
  logic [4:0] grant;
  logic [4:0] xbar_sel_N, xbar_sel_E, xbar_sel_W, xbar_sel_S, xbar_sel_L;
  logic [4:0] out_valid;
  logic       credit_err;

  int checks = 0;
  int errors = 0;

  credit_switch_allocator #(.CREDITS(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_N      (req_N),
    .req_E      (req_E),
    .req_W      (req_W),
    .req_S      (req_S),
    .req_L      (req_L),
    .tail       (tail),
    .credit_in  (credit_in),
    .grant      (grant),
    .xbar_sel_N (xbar_sel_N),
    .xbar_sel_E (xbar_sel_E),
    .xbar_sel_W (xbar_sel_W),
    .xbar_sel_S (xbar_sel_S),
    .xbar_sel_L (xbar_sel_L),
    .out_valid  (out_valid),
    .credit_err (credit_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    req_N = '0; req_E = '0; req_W = '0; req_S = '0; req_L = '0;
    tail = '0; credit_in = '0;
  endtask

  task automatic do_reset;
    clear_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    tick();
    check("reset_grant", 32'(grant), 32'b0);
    check("reset_out_valid", 32'(out_valid), 32'b0);
    check("reset_xsel_N", 32'(xbar_sel_N), 32'b0);
    check("reset_credit_err", 32'(credit_err), 32'b0);
    rst = 1'b0;

    // Round-robin between N and E contending for output N
    req_N = 5'b00001; req_E = 5'b00001; tail = 5'b11111;
    tick();
    check("rr_grant1", 32'(grant), 32'b00001);
    check("rr_xsel1", 32'(xbar_sel_N), 32'b00001);
    check("rr_valid1", 32'(out_valid), 32'b00001);
    tick();
    check("rr_grant2", 32'(grant), 32'b00010);
    check("rr_xsel2", 32'(xbar_sel_N), 32'b00010);
    clear_inputs();
    credit_in = 5'b00001;
    tick();
    check("rr_idle", 32'(grant), 32'b0);
    tick();
    credit_in = '0;
    check("rr_no_err", 32'(credit_err), 32'b0);

    // Packet lock: W holds output W for 3 flits, S follows
    do_reset();
    req_W = 5'b00100; req_S = 5'b00100; tail = 5'b11011;
    tick();
    check("lock_g1", 32'(grant), 32'b00100);
    check("lock_xsel1", 32'(xbar_sel_W), 32'b00100);
    tick();
    check("lock_g2", 32'(grant), 32'b00100);
    tail = 5'b11111;
    tick();
    check("lock_g3", 32'(grant), 32'b00100);
    tick();
    check("lock_s_grant", 32'(grant), 32'b01000);
    check("lock_s_xsel", 32'(xbar_sel_W), 32'b01000);
    tick();
    check("lock_no_credit", 32'(grant), 32'b0);
    check("lock_no_valid", 32'(out_valid), 32'b0);

    // Credit exhaustion and a single returned credit on output L
    do_reset();
    req_L = 5'b10000; tail = 5'b11111;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("cred_grant", 32'(grant), 32'b10000);
    end
    tick();
    check("cred_empty1", 32'(grant), 32'b0);
    tick();
    check("cred_empty2", 32'(grant), 32'b0);
    credit_in = 5'b10000;
    tick();
    check("cred_same_cycle", 32'(grant), 32'b0);
    credit_in = '0;
    tick();
    check("cred_returned", 32'(grant), 32'b10000);
    tick();
    check("cred_empty3", 32'(grant), 32'b0);

    // Credit overflow is sticky and the counter stays at CREDITS
    do_reset();
    credit_in = 5'b00001;
    tick();
    check("ovf_err", 32'(credit_err), 32'b1);
    credit_in = '0;
    req_N = 5'b00001; tail = 5'b11111;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("ovf_grant", 32'(grant), 32'b00001);
    end
    tick();
    check("ovf_capped", 32'(grant), 32'b0);
    check("ovf_sticky", 32'(credit_err), 32'b1);
    do_reset();
    check("ovf_cleared", 32'(credit_err), 32'b0);

    // Multi-hot request is ignored; E proceeds normally
    req_N = 5'b00011; req_E = 5'b00001; tail = 5'b00000;
    tick();
    check("mh_grant", 32'(grant), 32'b00010);
    check("mh_xsel_N", 32'(xbar_sel_N), 32'b00010);
    check("mh_valid", 32'(out_valid), 32'b00001);
    req_N = '0; req_E = '0; req_W = 5'b00010;
    tick();
    check("mh_e_unlocked", 32'(grant), 32'b00100);
    check("mh_xsel_E", 32'(xbar_sel_E), 32'b00100);

    // Reset mid-packet abandons the lock of output E to W
    do_reset();
    req_W = 5'b00010; tail = 5'b00000;
    tick();
    check("rstlk_grant", 32'(grant), 32'b00100);
    rst = 1'b1;
    tick();
    check("rstlk_rst_grant", 32'(grant), 32'b0);
    check("rstlk_rst_xsel", 32'(xbar_sel_E), 32'b0);
    rst = 1'b0;
    req_W = '0; req_S = 5'b00010;
    tick();
    check("rstlk_new_grant", 32'(grant), 32'b01000);
    check("rstlk_new_xsel", 32'(xbar_sel_E), 32'b01000);
    for (int n = 0; n < 3; n++) begin
      tick();
      check("rstlk_full_credit", 32'(grant), 32'b01000);
    end
    tick();
    check("rstlk_drained", 32'(grant), 32'b0);

    clear_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/credit_switch_allocator.md
CREDIT_SWITCH_ALLOCATOR -- requirements
Module: credit_switch_allocator

Interface
REQ-001 The block SHALL have parameter CREDITS, default 4, meaning the downstream buffer depth per output port (range 1..7).
REQ-002 The block SHALL use port index order 0=N, 1=E, 2=W, 3=S, 4=L for every 5-bit vector.
REQ-003 The block SHALL use reset rst, synchronous, active-high, and clock clk.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 req_N, req_E, req_W, req_S, req_L  input  5 each  one-hot requested output per input port; all-zero means no request.
REQ-007 tail  input  5  per-input tail flag; bit i is high when input i's current flit ends its packet.
REQ-008 credit_in  input  5  per-output credit-return pulse; one credit per bit per cycle.
REQ-009 grant  output  5  per-input grant; bit i high means input i's flit is forwarded this cycle.
REQ-010 xbar_sel_N, xbar_sel_E, xbar_sel_W, xbar_sel_S, xbar_sel_L  output  5 each  one-hot input selected for that output; zero when idle.
REQ-011 out_valid  output  5  per-output flit-forwarded strobe.
REQ-012 credit_err  output  1  sticky credit-overflow flag.

Function
REQ-013 Each output o SHALL hold a credit counter (3 bits) and a round-robin pointer rr_o (0..4), and SHALL run an FSM with states IDLE and LOCKED(owner).
REQ-014 A request vector that is not one-hot and not zero SHALL be treated as no request for that cycle.
REQ-015 In IDLE, output o SHALL select the first requesting input at or after rr_o (cyclic order 0..4). It SHALL grant only if credit_o > 0.
REQ-016 In LOCKED(owner), output o SHALL consider only the owner. It SHALL grant only if the owner requests o and credit_o > 0. Other requesters SHALL be ignored.
REQ-017 A grant on o with tail of the winner = 0 SHALL move the FSM to LOCKED(winner). A grant with tail = 1 SHALL move it, or keep it, in IDLE.
REQ-018 On any grant on o where the FSM ends the cycle in IDLE, rr_o SHALL become (winner+1) mod 5. rr_o SHALL NOT change otherwise.
REQ-019 grant, xbar_sel_* and out_valid SHALL be registered. Each SHALL reflect the decision made from the inputs sampled at the previous rising edge (latency 1 cycle).
REQ-020 At most one bit of each xbar_sel_* SHALL be set. An input SHALL be granted by at most one output per cycle; this holds by construction from the one-hot requests.
REQ-021 Credit update per output SHALL be: +1 on credit_in, -1 on grant, net 0 when both occur in the same cycle.
REQ-022 A credit_in that would raise the counter above CREDITS SHALL be discarded, and credit_err SHALL be set to 1 until reset.
REQ-023 When credit_o = 0, a locked output SHALL stay LOCKED with no grant. It SHALL resume the same owner when a credit returns.
REQ-024 A credit returned in cycle t SHALL be usable for a grant decided in cycle t+1, not in cycle t.

Reset
REQ-025 rst SHALL set all of the following on the next edge:
- every credit counter to CREDITS;
- every rr_o to 0;
- every FSM to IDLE;
- grant, out_valid and all xbar_sel_* to 0;
- credit_err to 0.
REQ-026 rst asserted mid-packet SHALL abandon all locks. Packets in flight SHALL receive no further grants until re-requested after reset.

Verification
REQ-027 After reset, req_N=req_E=00001 (both to N), tail=11111 -> cycle+1: grant=00001, xbar_sel_N=00001; next decision: grant=00010 (round-robin).
REQ-028 req_W=00100 held, tail=0 for 2 flits then 1, req_S=00100 concurrently -> W granted 3 consecutive cycles; S first granted on the cycle after W's tail.
REQ-029 CREDITS=4, req_L=10000 held, no credit_in -> exactly 4 grants, then grant stays 0. A credit_in[4] pulse -> exactly one further grant, one cycle later.
REQ-030 Credit counter full and credit_in=00001 -> credit_err=1, counter stays at 4; credit_err stays 1 until rst.
REQ-031 req_N=00011 (multi-hot) -> no grant and no lock; req_E=00001 in the same cycle is granted normally.
REQ-032 rst asserted while output E is LOCKED to W -> next cycle E is IDLE, all credits =CREDITS, and a new requester to E is granted at once.
